// File: rtl/scrambler_frame_ctrl.sv
// rtl/scrambler_frame_ctrl.sv - frame sequencer for the 220-bit, 18-bit-per-word LFSR scrambler
// Seeds the LFSR on start, absorbs one word per accepted transfer, and holds the final state for the consumer.
module scrambler_frame_ctrl #(
  parameter int STATE_W   = 220,
  parameter int STEP_W    = 18,
  parameter int MAX_WORDS = 1024,
  parameter int CNT_W     = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [STATE_W-1:0] seed,
  output logic               busy,
  input  logic [STEP_W-1:0]  in_data,
  input  logic               in_valid,
  input  logic               in_last,
  output logic               in_ready,
  output logic [STATE_W-1:0] out_state,
  output logic [CNT_W-1:0]   out_words,
  output logic               err_len,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int TAP_A = 23;
  localparam int TAP_B = 121;
  localparam int TAP_C = 168;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             fsm_q, fsm_d;
  logic [STATE_W-1:0] lfsr_q, lfsr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_inc;
  logic [STATE_W-1:0] lfsr_next;
  logic               xfer;

  // Bit 0 of the word enters first; all 18 shifts happen within a single cycle.
  function automatic logic [STATE_W-1:0] lfsr_step(input logic [STATE_W-1:0] s,
                                                   input logic [STEP_W-1:0]  d);
    logic [STATE_W-1:0] r;
    logic               msb;
    r = s;
    for (int i = 0; i < STEP_W; i++) begin
      msb      = r[STATE_W-1];
      r        = {r[STATE_W-2:0], msb ^ d[i]};
      r[TAP_A] = r[TAP_A] ^ msb;
      r[TAP_B] = r[TAP_B] ^ msb;
      r[TAP_C] = r[TAP_C] ^ msb;
    end
    return r;
  endfunction

  assign lfsr_next = lfsr_step(lfsr_q, in_data);
  assign cnt_inc   = cnt_q + 1'b1;
  assign in_ready  = (fsm_q == S_RUN);
  assign out_valid = (fsm_q == S_DONE);
  assign busy      = (fsm_q != S_IDLE);
  assign xfer      = in_valid & in_ready;
  assign out_state = lfsr_q;
  assign out_words = cnt_q;
  assign err_len   = err_q;

  always_comb begin
    fsm_d  = fsm_q;
    lfsr_d = lfsr_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    case (fsm_q)
      S_IDLE: begin
        if (start) begin
          lfsr_d = seed;
          cnt_d  = '0;
          err_d  = 1'b0;
          fsm_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (xfer) begin
          lfsr_d = lfsr_next;
          cnt_d  = cnt_inc;
          if (in_last) begin
            err_d = 1'b0;
            fsm_d = S_DONE;
          end else if (cnt_inc == CNT_W'(MAX_WORDS)) begin
            err_d = 1'b1;
            fsm_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (out_ready) begin
          fsm_d = S_IDLE;
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q  <= S_IDLE;
      lfsr_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      lfsr_q <= lfsr_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

endmodule

// File: tb/tb_scrambler_frame_ctrl.sv
// tb/tb_scrambler_frame_ctrl.sv - scoreboard bench for scrambler_frame_ctrl
// Stimulus pushes expected results; a negedge monitor pops them on each result handshake.
module tb_scrambler_frame_ctrl;

  localparam int STATE_W = 220;
  localparam int STEP_W  = 18;
  localparam int CNT_W   = 11;
  localparam int MAXW    = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [STATE_W-1:0] seed;
  logic               busy;
  logic [STEP_W-1:0]  in_data;
  logic               in_valid;
  logic               in_last;
  logic               in_ready;
  logic [STATE_W-1:0] out_state;
  logic [CNT_W-1:0]   out_words;
  logic               err_len;
  logic               out_valid;
  logic               out_ready;

  typedef struct packed {
    logic [STATE_W-1:0] st;
    logic [CNT_W-1:0]   w;
    logic               e;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  logic [STATE_W-1:0] one = 1;
  logic [STATE_W-1:0] exp_st;
  logic [STATE_W-1:0] held_st;
  logic [CNT_W-1:0]   held_w;

  always #5 clk = ~clk;

  scrambler_frame_ctrl #(.STATE_W(STATE_W), .STEP_W(STEP_W), .MAX_WORDS(MAXW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .busy(busy),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_state(out_state), .out_words(out_words), .err_len(err_len),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  task automatic chk(input string name, input logic [STATE_W-1:0] act, input logic [STATE_W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Result monitor: every out_valid & out_ready handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_result actual_words=%0d required=none", out_words);
      end else begin
        e = sb.pop_front();
        if (out_state !== e.st || out_words !== e.w || err_len !== e.e) begin
          failures++;
          $display("FAIL result actual=%0h/%0d/%0b required=%0h/%0d/%0b",
                   out_state, out_words, err_len, e.st, e.w, e.e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [STATE_W-1:0] s);
    seed  = s;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_to_in_ready", {219'b0, in_ready}, 1);
  endtask

  task automatic send(input logic [STEP_W-1:0] d, input logic last);
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic push(input logic [STATE_W-1:0] st, input int w, input logic e);
    exp_t x;
    x.st = st;
    x.w  = CNT_W'(w);
    x.e  = e;
    sb.push_back(x);
  endtask

  // Waits (bounded) for the scoreboard to drain and the controller to return to IDLE.
  task automatic finish_frame(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 20) begin
      tick();
      n++;
    end
    chk(name, {219'b0, (n < 20) ? 1'b1 : 1'b0}, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; seed = '0;
    in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("reset_busy", {219'b0, busy}, 0);
    chk("reset_in_ready", {219'b0, in_ready}, 0);
    chk("reset_out_valid", {219'b0, out_valid}, 0);
    chk("reset_out_state", out_state, 0);
    chk("reset_out_words", {209'b0, out_words}, 0);
    chk("reset_err_len", {219'b0, err_len}, 0);

    // Single set bit lands at position 17 after 18 shifts.
    do_start('0);
    push(one << 17, 1, 1'b0);
    send(18'h00001, 1'b1);
    chk("last_to_out_valid", {219'b0, out_valid}, 1);
    finish_frame("frame1_done");

    // MSB feedback hits bit 0 and all three taps, then shifts 17 more places.
    do_start(one << 219);
    exp_st = (one << 17) | (one << 40) | (one << 138) | (one << 185);
    push(exp_st, 1, 1'b0);
    send(18'h00000, 1'b1);
    finish_frame("frame2_done");

    // Gap of two idle cycles, with a stray in_last while in_valid is low.
    do_start('0);
    send(18'h00001, 1'b0);
    in_last = 1'b1;
    tick(); tick();
    in_last = 1'b0;
    chk("gap_words", {209'b0, out_words}, 1);
    chk("gap_state", out_state, one << 17);
    chk("gap_busy", {219'b0, busy}, 1);
    send(18'h00000, 1'b0);
    push(one << 53, 3, 1'b0);
    send(18'h00000, 1'b1);
    finish_frame("frame3_done");

    // Forced close at MAX_WORDS without in_last.
    do_start('0);
    send(18'h00001, 1'b0);
    send(18'h00000, 1'b0);
    send(18'h00000, 1'b0);
    push(one << 71, 4, 1'b1);
    send(18'h00000, 1'b0);
    chk("maxw_out_valid", {219'b0, out_valid}, 1);
    finish_frame("frame4_done");

    // in_last on the MAX_WORDS-th word closes normally.
    do_start('0);
    send(18'h00000, 1'b0);
    send(18'h00000, 1'b0);
    send(18'h00000, 1'b0);
    push(one << 17, 4, 1'b0);
    send(18'h00001, 1'b1);
    finish_frame("frame5_done");

    // Backpressure: result held, start pulses ignored.
    out_ready = 1'b0;
    do_start(one << 219);
    send(18'h00000, 1'b0);
    send(18'h00000, 1'b1);
    held_st = out_state;
    held_w  = out_words;
    chk("bp_words", {209'b0, held_w}, 2);
    for (int i = 0; i < 10; i++) begin
      seed  = {STATE_W{1'b1}};
      start = i[0];
      tick();
      chk("bp_out_valid", {219'b0, out_valid}, 1);
      chk("bp_in_ready", {219'b0, in_ready}, 0);
      chk("bp_state_stable", out_state, held_st);
      chk("bp_words_stable", {209'b0, out_words}, {209'b0, held_w});
    end
    push(held_st, 2, 1'b0);
    start = 1'b1;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    chk("bp_release_idle", {219'b0, busy}, 0);
    chk("bp_retained_state", out_state, held_st);
    finish_frame("frame6_done");
    do_start('0);
    push((one << 17) | (one << 16), 1, 1'b0);
    send(18'h00003, 1'b1);
    finish_frame("frame7_done");

    // Reset mid-frame discards the partial frame.
    do_start(one << 219);
    send(18'h00005, 1'b0);
    send(18'h00007, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", {219'b0, busy}, 0);
    chk("midrst_in_ready", {219'b0, in_ready}, 0);
    chk("midrst_out_valid", {219'b0, out_valid}, 0);
    chk("midrst_state", out_state, 0);
    chk("midrst_words", {209'b0, out_words}, 0);
    chk("midrst_err", {219'b0, err_len}, 0);
    do_start('0);
    push(one << 17, 1, 1'b0);
    send(18'h00001, 1'b1);
    finish_frame("frame8_done");

    tick(); tick();
    chk("scoreboard_empty", STATE_W'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
